// File: rtl/cordic_vec_ctrl_if.sv
// Handshake and data bundle for the CORDIC vectoring controller.
// master drives the input pair and out_ready; slave is the controller.
interface cordic_vec_ctrl_if #(
  parameter int DATA_LENGTH = 13,
  parameter int ITER_NUM    = 12
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [DATA_LENGTH-1:0] in_X;
  logic signed [DATA_LENGTH-1:0] in_Y;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [DATA_LENGTH-1:0] out_X;
  logic signed [DATA_LENGTH-1:0] out_Y;
  logic [ITER_NUM-1:0]           out_signs;
  logic                          out_neg;
  logic                          busy;

  modport master (
    output in_valid, in_X, in_Y, out_ready,
    input  in_ready, out_valid, out_X, out_Y, out_signs, out_neg, busy
  );

  modport slave (
    input  in_valid, in_X, in_Y, out_ready,
    output in_ready, out_valid, out_X, out_Y, out_signs, out_neg, busy
  );
endinterface

// File: rtl/cordic_vec_ctrl.sv
// Iterative CORDIC vectoring controller, two micro-rotations per clock.
// Optional gain compensation stage is enabled with macro CORDIC_GAIN_COMP_EN.
module cordic_vec_ctrl #(
  parameter int DATA_LENGTH = 13,
  parameter int ITER_NUM    = 12,
  parameter int ITER_IDX    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  cordic_vec_ctrl_if.slave  bus
);

  localparam int W = DATA_LENGTH;

  typedef logic signed [W-1:0] data_t;
  typedef logic [ITER_IDX-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam idx_t K_LAST = idx_t'(ITER_NUM - 2);

  // One micro-rotation: returns {d_k, X', Y'}; sums wrap at W bits.
  function automatic logic [2*W:0] micro_rot(input data_t x, input data_t y, input idx_t k);
    data_t xs;
    data_t ys;
    logic  d;
    xs = x >>> k;
    ys = y >>> k;
    d  = y[W-1];
    if (d) begin
      return {d, data_t'(x - ys), data_t'(y + xs)};
    end else begin
      return {d, data_t'(x + ys), data_t'(y - xs)};
    end
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  // Multiply by ~0.6074 using truncated shift-add terms.
  function automatic data_t gain_comp(input data_t v);
    return data_t'((v >>> 4'd1) + (v >>> 4'd3) - (v >>> 4'd6) - (v >>> 4'd9));
  endfunction
`endif

  state_t              state_r, state_nxt_s;
  data_t               x_r, x_nxt_s;
  data_t               y_r, y_nxt_s;
  idx_t                k_r, k_nxt_s;
  logic [ITER_NUM-1:0] signs_r, signs_nxt_s;
  logic                neg_r, neg_nxt_s;

  logic                in_ready_r;
  logic                busy_r;
  logic                out_valid_r, out_valid_nxt_s;
  data_t               out_x_r, out_x_nxt_s;
  data_t               out_y_r, out_y_nxt_s;
  logic [ITER_NUM-1:0] out_signs_r, out_signs_nxt_s;
  logic                out_neg_r, out_neg_nxt_s;

  logic [2*W:0]        rot0_s;
  logic [2*W:0]        rot1_s;
  idx_t                k1_s;

  // Two chained stages: k and k+1, the second fed by the first.
  assign k1_s   = k_r + idx_t'(1);
  assign rot0_s = micro_rot(data_t'(x_r), data_t'(y_r), k_r);
  assign rot1_s = micro_rot(data_t'(rot0_s[2*W-1:W]), data_t'(rot0_s[W-1:0]), k1_s);

  // Next-state and datapath update for all FSM states.
  always_comb begin
    state_nxt_s     = state_r;
    x_nxt_s         = x_r;
    y_nxt_s         = y_r;
    k_nxt_s         = k_r;
    signs_nxt_s     = signs_r;
    neg_nxt_s       = neg_r;
    out_valid_nxt_s = out_valid_r;
    out_x_nxt_s     = out_x_r;
    out_y_nxt_s     = out_y_r;
    out_signs_nxt_s = out_signs_r;
    out_neg_nxt_s   = out_neg_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // Left half-plane inputs are negated into the right half-plane.
          if (bus.in_X[W-1]) begin
            x_nxt_s   = data_t'(-bus.in_X);
            y_nxt_s   = data_t'(-bus.in_Y);
            neg_nxt_s = 1'b1;
          end else begin
            x_nxt_s   = bus.in_X;
            y_nxt_s   = bus.in_Y;
            neg_nxt_s = 1'b0;
          end
          signs_nxt_s = '0;
          k_nxt_s     = '0;
          state_nxt_s = ST_ITER;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_ITER: begin
        x_nxt_s = data_t'(rot1_s[2*W-1:W]);
        y_nxt_s = data_t'(rot1_s[W-1:0]);
        for (int i = 0; i < ITER_NUM; i++) begin
          if (idx_t'(i) == k_r) begin
            signs_nxt_s[i] = rot0_s[2*W];
          end else if (idx_t'(i) == k1_s) begin
            signs_nxt_s[i] = rot1_s[2*W];
          end else begin
            signs_nxt_s[i] = signs_r[i];
          end
        end
        k_nxt_s = k_r + idx_t'(2);
        if (k_r == K_LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_nxt_s = ST_COMP;
`else
          state_nxt_s = ST_DONE;
`endif
        end else begin
          state_nxt_s = ST_ITER;
        end
      end

`ifdef CORDIC_GAIN_COMP_EN
      ST_COMP: begin
        x_nxt_s     = gain_comp(x_r);
        y_nxt_s     = gain_comp(y_r);
        state_nxt_s = ST_DONE;
      end
`endif

      ST_DONE: begin
        // First DONE cycle captures the result; afterwards wait for out_ready.
        if (!out_valid_r) begin
          out_valid_nxt_s = 1'b1;
          out_x_nxt_s     = x_r;
          out_y_nxt_s     = y_r;
          out_signs_nxt_s = signs_r;
          out_neg_nxt_s   = neg_r;
          state_nxt_s     = ST_DONE;
        end else if (bus.out_ready) begin
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_IDLE;
        end else begin
          out_valid_nxt_s = 1'b1;
          state_nxt_s     = ST_DONE;
        end
      end

      default: begin
        out_valid_nxt_s = 1'b0;
        state_nxt_s     = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      x_r         <= '0;
      y_r         <= '0;
      k_r         <= '0;
      signs_r     <= '0;
      neg_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_x_r     <= '0;
      out_y_r     <= '0;
      out_signs_r <= '0;
      out_neg_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      x_r         <= x_nxt_s;
      y_r         <= y_nxt_s;
      k_r         <= k_nxt_s;
      signs_r     <= signs_nxt_s;
      neg_r       <= neg_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      out_valid_r <= out_valid_nxt_s;
      out_x_r     <= out_x_nxt_s;
      out_y_r     <= out_y_nxt_s;
      out_signs_r <= out_signs_nxt_s;
      out_neg_r   <= out_neg_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_X     = out_x_r;
  assign bus.out_Y     = out_y_r;
  assign bus.out_signs = out_signs_r;
  assign bus.out_neg   = out_neg_r;

endmodule
